// File: rtl/ag6502_ext_clock_if.sv
// Phase-0 reference in, two-phase non-overlapping clocks out.
interface ag6502_ext_clock_if;
  logic clk1;
  logic phi_1;
  logic phi_2;

  modport master (output clk1, input  phi_1, phi_2);
  modport slave  (input  clk1, output phi_1, phi_2);
endinterface

// File: rtl/ag6502_ext_clock.sv
// Two-phase non-overlapping clock generator: derives phi_1/phi_2 from a slow
// phase-0 reference, with programmable dead time counted in clk cycles.
module ag6502_ext_clock #(
  parameter int unsigned DELAY1 = 3,
  parameter int unsigned DELAY2 = 1
) (
  input  logic               clk,
  input  logic               reset,
  ag6502_ext_clock_if.slave  bus
);
  localparam logic [7:0] D1M1 = 8'(DELAY1 - 1);
  localparam logic [7:0] D2M1 = 8'(DELAY2 - 1);

  typedef enum logic [1:0] {IDLE, CNT_PHI1, CNT_PHI2} state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       s1, s2, d;
  logic       phi_1_q, phi_1_n;
  logic       phi_2_q, phi_2_n;
  logic       rise, fall;

  assign rise = s2 & ~d;
  assign fall = ~s2 & d;

  assign bus.phi_1 = phi_1_q;
  assign bus.phi_2 = phi_2_q;

  // Reset arms a phi_1 countdown so phi_1 comes up on its own with clk1 low.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      d       <= 1'b0;
      phi_1_q <= 1'b0;
      phi_2_q <= 1'b0;
      cnt     <= D2M1;
      state   <= CNT_PHI1;
    end else begin
      s1      <= bus.clk1;
      s2      <= s1;
      d       <= s2;
      phi_1_q <= phi_1_n;
      phi_2_q <= phi_2_n;
      cnt     <= cnt_n;
      state   <= state_n;
    end
  end

  // An edge event always drops the opposite phase first and restarts the
  // countdown, so a pending rise is cancelled when clk1 toggles too fast.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phi_1_n = phi_1_q;
    phi_2_n = phi_2_q;
    if (rise) begin
      phi_1_n = 1'b0;
      cnt_n   = D1M1;
      state_n = CNT_PHI2;
    end else if (fall) begin
      phi_2_n = 1'b0;
      cnt_n   = D2M1;
      state_n = CNT_PHI1;
    end else if (state != IDLE) begin
      if (cnt != 8'd0) begin
        cnt_n = cnt - 8'd1;
      end else begin
        if (state == CNT_PHI2) phi_2_n = 1'b1;
        else                   phi_1_n = 1'b1;
        state_n = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ag6502_ext_clock.sv
// Directed bench for ag6502_ext_clock: three instances with different dead times
// share one clk1 stimulus.
module tb_ag6502_ext_clock;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk1 = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ag6502_ext_clock_if ifa ();
  ag6502_ext_clock_if ifb ();
  ag6502_ext_clock_if ifc ();
  assign ifa.clk1 = clk1;
  assign ifb.clk1 = clk1;
  assign ifc.clk1 = clk1;

  ag6502_ext_clock #(.DELAY1(3), .DELAY2(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  ag6502_ext_clock #(.DELAY1(2), .DELAY2(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  ag6502_ext_clock #(.DELAY1(8), .DELAY2(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle overlap check and phi_2 rising-edge counters.
  logic mon_en = 1'b0;
  logic cnt_en = 1'b0;
  int   rise_a = 0, rise_b = 0, rise_c = 0;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("overlap_a", 32'(ifa.phi_1 & ifa.phi_2), 32'd0);
      chk("overlap_b", 32'(ifb.phi_1 & ifb.phi_2), 32'd0);
      chk("overlap_c", 32'(ifc.phi_1 & ifc.phi_2), 32'd0);
      if (cnt_en) begin
        if (ifa.phi_2 && !pa) rise_a++;
        if (ifb.phi_2 && !pb) rise_b++;
        if (ifc.phi_2 && !pc) rise_c++;
      end
      pa = ifa.phi_2;
      pb = ifb.phi_2;
      pc = ifc.phi_2;
    end
  end

  initial begin
    int hb1, hb2, ha1, ha2, len_h, len_l, total, exp_a, exp_b, exp_c;

    // Reset 4 cycles with clk1 low; phi_1 comes up on the first cycle after release.
    for (int i = 0; i < 4; i++) begin
      tick();
      mon_en = 1'b1;
      chk("rst_phi1", 32'(ifa.phi_1), 32'd0);
      chk("rst_phi2", 32'(ifa.phi_2), 32'd0);
    end
    reset = 1'b0;
    tick();
    chk("rel_phi1_a", 32'(ifa.phi_1), 32'd1);
    chk("rel_phi2_a", 32'(ifa.phi_2), 32'd0);
    chk("rel_phi1_c", 32'(ifc.phi_1), 32'd1);

    // Default timing: clk1 rises at edge N, phi_1 falls at N+3, phi_2 rises at N+6.
    tick(5);
    clk1 = 1'b1;
    tick(2);
    chk("n2_phi1_a", 32'(ifa.phi_1), 32'd1);
    tick();
    chk("n3_phi1_a", 32'(ifa.phi_1), 32'd0);
    tick(2);
    chk("n5_phi2_a", 32'(ifa.phi_2), 32'd0);
    chk("n5_phi2_b", 32'(ifb.phi_2), 32'd1);
    tick();
    chk("n6_phi2_a", 32'(ifa.phi_2), 32'd1);
    tick(4);
    chk("n10_phi2_c", 32'(ifc.phi_2), 32'd0);
    tick();
    chk("n11_phi2_c", 32'(ifc.phi_2), 32'd1);
    clk1 = 1'b0;
    tick(3);
    chk("fall_phi2_a", 32'(ifa.phi_2), 32'd0);
    chk("fall_phi1_a", 32'(ifa.phi_1), 32'd0);
    tick();
    chk("fall1_phi1_a", 32'(ifa.phi_1), 32'd1);

    // Short clk1 pulse (3 cycles): DELAY1=8 and DELAY1=3 never raise phi_2.
    tick(5);
    cnt_en = 1'b1;
    clk1 = 1'b1;
    tick(3);
    clk1 = 1'b0;
    tick(3);
    chk("short_phi1_c", 32'(ifc.phi_1), 32'd0);
    tick();
    chk("short_phi1_c_up", 32'(ifc.phi_1), 32'd1);
    tick(10);
    cnt_en = 1'b0;
    chk("short_rise_c", 32'(rise_c), 32'd0);
    chk("short_rise_a", 32'(rise_a), 32'd0);
    chk("short_rise_b", 32'(rise_b), 32'd1);

    // clk1 = clk/10: duty of each phase over one locked period.
    hb1 = 0; hb2 = 0; ha1 = 0; ha2 = 0;
    for (int i = 0; i < 90; i++) begin
      clk1 = ((i % 10) < 5);
      tick();
      if (i >= 80) begin
        hb1 += int'(ifb.phi_1);
        hb2 += int'(ifb.phi_2);
        ha1 += int'(ifa.phi_1);
        ha2 += int'(ifa.phi_2);
      end
    end
    chk("div10_phi2_b", 32'(hb2), 32'd3);
    chk("div10_phi1_b", 32'(hb1), 32'd4);
    chk("div10_phi2_a", 32'(ha2), 32'd2);
    chk("div10_phi1_a", 32'(ha1), 32'd4);

    // Reset while phi_2 high and clk1 high, then re-lock.
    clk1 = 1'b1;
    tick(12);
    chk("pre_rst_phi2_a", 32'(ifa.phi_2), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_phi1_a", 32'(ifa.phi_1), 32'd0);
    chk("mid_rst_phi2_a", 32'(ifa.phi_2), 32'd0);
    chk("mid_rst_phi2_c", 32'(ifc.phi_2), 32'd0);
    tick();
    reset = 1'b0;
    tick(3);
    chk("rerise_phi1_a", 32'(ifa.phi_1), 32'd0);
    tick(2);
    chk("rerise5_phi2_a", 32'(ifa.phi_2), 32'd0);
    tick();
    chk("rerise6_phi2_a", 32'(ifa.phi_2), 32'd1);

    // Random high/low periods; high lengths of exactly DELAY1+1 are skipped.
    clk1 = 1'b0;
    tick(15);
    rise_a = 0; rise_b = 0; rise_c = 0;
    exp_a = 0; exp_b = 0; exp_c = 0;
    total = 0;
    cnt_en = 1'b1;
    while (total < 10000) begin
      len_h = int'($urandom_range(1, 12));
      while (len_h == 3 || len_h == 4 || len_h == 9) len_h = int'($urandom_range(1, 12));
      len_l = int'($urandom_range(1, 6));
      clk1 = 1'b1;
      tick(len_h);
      clk1 = 1'b0;
      tick(len_l);
      total += len_h + len_l;
      if (len_h >= 5)  exp_a++;
      if (len_h >= 4)  exp_b++;
      if (len_h >= 10) exp_c++;
    end
    tick(20);
    cnt_en = 1'b0;
    chk("rand_rise_a", 32'(rise_a), 32'(exp_a));
    chk("rand_rise_b", 32'(rise_b), 32'(exp_b));
    chk("rand_rise_c", 32'(rise_c), 32'(exp_c));

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
